// File: rtl/clk_div_nch.sv
// clk_div_nch
//   Multi-channel programmable clock divider. Each of NCH channels divides
//   clock_out1 by its own ratio N (2..2^DW-1), starting from a programmable
//   phase. Ratio/phase updates and disables only take effect at a period
//   boundary, so outputs never produce runt pulses. sync_in realigns every
//   running channel to its phase.
//
// Ports
//   clock_out1  fast source clock (rising edge)
//   rst_n       asynchronous active-low reset
//   cfg_valid   configuration request
//   cfg_ready   low while the addressed channel has an update pending
//   cfg_ch      target channel
//   cfg_div     divide ratio N
//   cfg_phase   counter start value
//   cfg_err     one-cycle pulse after a rejected request
//   en          per-channel run enable (level)
//   sync_in     one-cycle realign pulse
//   clk_out     derived clocks (flop outputs)
//   active      channel running
module clk_div_nch #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clock_out1,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  input  logic [DW-1:0]  cfg_phase,
  output logic           cfg_err,
  input  logic [NCH-1:0] en,
  input  logic           sync_in,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] active
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam int          NSEL  = 1 << CW;
  localparam logic [CW:0] NCH_W = (CW + 1)'(NCH);

  logic [NCH-1:0]  pending;
  logic [NSEL-1:0] pend_pad;
  logic            ch_ok;
  logic            div_ok;
  logic            cfg_take;
  logic            cfg_store;
  logic            cfg_reject;

  // Unpopulated channel numbers read as "not pending", so an out-of-range
  // request is taken and then rejected rather than stalling forever.
  always_comb begin
    pend_pad          = '0;
    pend_pad[NCH-1:0] = pending;
  end

  assign cfg_ready  = ~pend_pad[cfg_ch];
  assign ch_ok      = ({1'b0, cfg_ch} < NCH_W);
  assign div_ok     = (cfg_div >= DW'(2));
  assign cfg_take   = cfg_valid & cfg_ready;
  assign cfg_store  = cfg_take & ch_ok & div_ok;
  assign cfg_reject = cfg_take & ~(ch_ok & div_ok);

  always_ff @(posedge clock_out1 or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_reject;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e        st;
    state_e        st_n;
    logic [DW-1:0] cnt;
    logic [DW-1:0] div_act;
    logic [DW-1:0] ph_act;
    logic [DW-1:0] div_pend;
    logic [DW-1:0] ph_pend;
    logic [DW-1:0] cnt_n;
    logic [DW-1:0] div_n;
    logic [DW-1:0] ph_n;
    logic [DW-1:0] ph_eff_n;
    logic [DW:0]   hi_n;
    logic          pend_q;
    logic          clk_q;
    logic          apply;
    logic          wrap;
    logic          sel;

    assign sel  = (cfg_ch == CW'(i));
    assign wrap = (cnt == div_act - DW'(1));

    // Next-state: decide whether a pending update lands this cycle, then
    // derive the counter from the ratio/phase that will be in force.
    always_comb begin
      apply = 1'b0;
      st_n  = st;
      case (st)
        ST_IDLE: begin
          apply = pend_q;
          if (en[i]) st_n = ST_RUN;
        end
        ST_RUN: begin
          if (sync_in) begin
            apply = pend_q;
          end else if (wrap) begin
            apply = pend_q;
            if (!en[i]) st_n = ST_IDLE;
          end
        end
        default: ;
      endcase

      div_n    = apply ? div_pend : div_act;
      ph_n     = apply ? ph_pend  : ph_act;
      ph_eff_n = (ph_n < div_n) ? ph_n : '0;
      hi_n     = ({1'b0, div_n} + (DW + 1)'(1)) >> 1;

      if (st == ST_IDLE || sync_in || st_n == ST_IDLE) cnt_n = ph_eff_n;
      else if (wrap)                                   cnt_n = '0;
      else                                             cnt_n = cnt + DW'(1);
    end

    always_ff @(posedge clock_out1 or negedge rst_n) begin
      if (!rst_n) begin
        st       <= ST_IDLE;
        cnt      <= '0;
        div_act  <= DW'(2);
        ph_act   <= '0;
        div_pend <= DW'(2);
        ph_pend  <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
      end else begin
        st      <= st_n;
        cnt     <= cnt_n;
        div_act <= div_n;
        ph_act  <= ph_n;
        // Output is computed from the counter value being written, so the
        // flop output lines up with cnt.
        clk_q   <= (st_n == ST_RUN) && ({1'b0, cnt_n} < hi_n);
        if (apply) begin
          pend_q <= 1'b0;
        end else if (cfg_store && sel) begin
          pend_q   <= 1'b1;
          div_pend <= cfg_div;
          ph_pend  <= cfg_phase;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign active[i]  = (st == ST_RUN);
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_nch.sv
module tb_clk_div_nch;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cfg_valid, cfg_ready, cfg_err, sync_in;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div, cfg_phase;
  logic [3:0] en, clk_out, active;

  logic       v2, r2, e2;
  logic [2:0] ch2;
  logic [4:0] en2, clk2, act2;

  clk_div_nch dut (
    .clock_out1(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .en(en), .sync_in(sync_in), .clk_out(clk_out), .active(active)
  );

  clk_div_nch #(.NCH(5)) dut5 (
    .clock_out1(clk), .rst_n(rst_n), .cfg_valid(v2), .cfg_ready(r2),
    .cfg_ch(ch2), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(e2),
    .en(en2), .sync_in(sync_in), .clk_out(clk2), .active(act2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: each running channel holds a queue of the output bits still to
  // come in its current period; a new period is generated whenever the
  // queue runs dry, and that is where updates and disables take effect.
  int         m_n[NCH], m_ph[NCH], m_pn[NCH], m_pph[NCH];
  bit         m_run[NCH], m_pend[NCH];
  int         m_q[NCH][$];
  logic [3:0] exp_clk = '0, exp_act = '0;
  logic       exp_err = 1'b0;

  function automatic int peff(input int n, input int p);
    return (p < n) ? p : 0;
  endfunction

  function automatic void push_period(input int c, input int from);
    for (int k = from; k < m_n[c]; k++) m_q[c].push_back((k < (m_n[c] + 1) / 2) ? 1 : 0);
  endfunction

  function automatic void m_apply(input int c);
    if (m_pend[c]) begin
      m_n[c] = m_pn[c]; m_ph[c] = m_pph[c]; m_pend[c] = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_n[c] = 2; m_ph[c] = 0; m_pend[c] = 0;
        m_pn[c] = 2; m_pph[c] = 0; m_q[c].delete();
      end
      exp_clk = '0; exp_act = '0; exp_err = 1'b0;
    end else begin
      int ch;
      bit rdy, take, bad;
      ch   = int'(cfg_ch);
      rdy  = (ch < NCH) ? !m_pend[ch] : 1'b1;
      take = (cfg_valid === 1'b1) && rdy;
      bad  = take && (cfg_div < 2 || ch >= NCH);
      for (int c = 0; c < NCH; c++) begin
        bit o;
        o = 0;
        if (!m_run[c]) begin
          m_apply(c);
          if (en[c]) begin
            m_run[c] = 1; m_q[c].delete(); push_period(c, peff(m_n[c], m_ph[c]));
            o = m_q[c].pop_front();
          end
        end else if (sync_in) begin
          m_apply(c);
          m_q[c].delete(); push_period(c, peff(m_n[c], m_ph[c]));
          o = m_q[c].pop_front();
        end else if (m_q[c].size() == 0) begin
          m_apply(c);
          if (!en[c]) m_run[c] = 0;
          else begin
            push_period(c, 0); o = m_q[c].pop_front();
          end
        end else begin
          o = m_q[c].pop_front();
        end
        exp_clk[c] = o;
        exp_act[c] = m_run[c];
      end
      if (take && !bad) begin
        m_pend[ch] = 1; m_pn[ch] = int'(cfg_div); m_pph[ch] = int'(cfg_phase);
      end
      exp_err = bad;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      chk("clk_out", clk_out, exp_clk);
      chk("active", active, exp_act);
      chk("cfg_err", cfg_err, exp_err);
      chk("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
    end
  end

  logic [3:0] hist_c[64], hist_a[64];

  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hist_c[i] = clk_out; hist_a[i] = active;
    end
  endtask

  function automatic logic [31:0] seqc(input int ch, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], hist_c[i][ch]};
    return v;
  endfunction

  function automatic logic [31:0] seqa(input int ch, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], hist_a[i][ch]};
    return v;
  endfunction

  int          t5_ch[4]  = '{5, 7, 4, 0};
  logic [7:0]  t5_div[4] = '{8'd4, 8'd4, 8'd3, 8'd1};
  logic        t5_err[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_phase = 0;
    en = '0; sync_in = 0; v2 = 0; ch2 = 0; en2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_clk", clk_out, 4'b0000);
    chk("rst_active", active, 4'b0000);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_err", cfg_err, 1'b0);

    // Default ratio 2 on channel 0.
    @(negedge clk); en = 4'b0001;
    cap(6);
    chk("ch0_div2", seqc(0, 6), 32'b101010);
    chk("ch0_only_active", active, 4'b0001);

    // Channel 1 at N=5.
    @(negedge clk); cfg_valid = 1; cfg_ch = 1; cfg_div = 5; cfg_phase = 0;
    @(posedge clk); #1; chk("ready_drop", cfg_ready, 1'b0);
    @(negedge clk); cfg_valid = 0;
    @(posedge clk); #1; chk("ready_back", cfg_ready, 1'b1);
    @(negedge clk); en[1] = 1;
    cap(10);
    chk("ch1_div5", seqc(1, 10), 32'b1110011100);

    // Drop en[1] in the 2nd cycle of a period.
    repeat (3) @(negedge clk);
    en[1] = 0;
    cap(5);
    chk("ch1_dis_clk", seqc(1, 5), 32'b10000);
    chk("ch1_dis_act", seqa(1, 5), 32'b11100);

    // Channel 2: N=4, retuned to N=6 mid-period.
    @(negedge clk); cfg_valid = 1; cfg_ch = 2; cfg_div = 4; cfg_phase = 0;
    @(negedge clk); cfg_valid = 0;
    @(negedge clk); en[2] = 1;
    fork
      cap(13);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        cfg_valid = 1; cfg_div = 6;
        @(negedge clk); cfg_valid = 0;
      end
    join
    chk("ch2_retune", seqc(2, 13), 32'b1100111000111);

    // Phase offset and sync: ch0 N=8 ph0, ch3 N=8 ph4.
    @(negedge clk); cfg_valid = 1; cfg_ch = 0; cfg_div = 8; cfg_phase = 0;
    @(negedge clk); cfg_valid = 0;
    repeat (3) @(negedge clk);
    cfg_valid = 1; cfg_ch = 3; cfg_div = 8; cfg_phase = 4;
    @(negedge clk); cfg_valid = 0;
    repeat (2) @(negedge clk);
    en[3] = 1;
    repeat (5) @(negedge clk);
    fork
      begin sync_in = 1; @(negedge clk); sync_in = 0; end
      cap(16);
    join
    chk("sync_ch0", seqc(0, 16), 32'b1111000011110000);
    chk("sync_ch3", seqc(3, 16), 32'b0000111100001111);

    // Illegal ratio, legal ratio 5 with phase == N.
    @(negedge clk); cfg_valid = 1; cfg_ch = 1; cfg_div = 1; cfg_phase = 0;
    @(posedge clk); #1; chk("err_div1", cfg_err, 1'b1);
    @(negedge clk); cfg_valid = 0;
    @(posedge clk); #1; chk("err_one_cycle", cfg_err, 1'b0);
    @(negedge clk); cfg_valid = 1; cfg_ch = 1; cfg_div = 5; cfg_phase = 5;
    @(posedge clk); #1; chk("err_legal", cfg_err, 1'b0);
    @(negedge clk); cfg_valid = 0;
    @(negedge clk); en[1] = 1;
    cap(7);
    chk("ch1_phase_eq_div", seqc(1, 7), 32'b1110011);
    @(negedge clk); cfg_valid = 1; cfg_ch = 3; cfg_div = 0;
    @(posedge clk); #1; chk("err_div0", cfg_err, 1'b1);
    @(negedge clk); cfg_valid = 0;

    // Channel number out of range on a 5-channel instance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); v2 = 1; ch2 = 3'(t5_ch[i]); cfg_div = t5_div[i];
      #1; chk("ready5", r2, 1'b1);
      @(posedge clk); #1; chk("err_ch_range", e2, t5_err[i]);
      @(negedge clk); v2 = 0;
    end

    // Asynchronous reset while outputs are high.
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (exp_clk != 4'b0000) break;
      @(posedge clk);
    end
    #2; rst_n = 0;
    #1;
    chk("async_rst_clk", clk_out, 4'b0000);
    chk("async_rst_act", active, 4'b0000);
    en = 4'b0001;
    repeat (2) @(negedge clk);
    rst_n = 1;
    cap(4);
    chk("post_rst_div2", seqc(0, 4), 32'b1010);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
